part_2_trgt_upld_buf: RTL and testbench

PART_2_TRGT_UPLD_BUF -- requirements
Module: part_2_trgt_upld_buf

---
 rtl/part_2_trgt_upld_buf.sv | 124 ++++++++++++
 tb/tb_part_2_trgt_upld_buf.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/part_2_trgt_upld_buf.sv
// Upload buffer: samples the DUT output on each mission-clock rising edge into a
// first-word-fall-through FIFO, with freeze backpressure and overflow accounting.
module part_2_trgt_upld_buf #(
  parameter int DEPTH     = 4,
  parameter int FREEZE_TH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_0_h,
  input  logic                     freeze_i,
  input  logic                     flush_i,
  input  logic                     sut_valid_i,
  input  logic [7:0]               sut_data_i,
  output logic                     vec_valid_o,
  output logic [8:0]               vec_data_o,
  output logic [7:0]               vec_seq_o,
  input  logic                     vec_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     freeze_req_o,
  output logic                     ovf_o,
  output logic [7:0]               ovf_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE_C = LW'(1'b1);
  localparam logic [LW-1:0] LVL_FULL_C = LW'(DEPTH);
  localparam logic [31:0] FREEZE_TH_C = 32'(FREEZE_TH);

  // Entry layout: {sut_valid, sut_data[7:0], seq[7:0]}
  logic [16:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [7:0]    seq_cnt_r;
  logic          ovf_r;
  logic [7:0]    ovf_cnt_r;
  logic          clk_0_h_d_r;

  logic          cap_s;
  logic          pop_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;
  logic [LW-1:0] level_nxt_s;
  logic [16:0]   head_s;

  // Capture strobe, push/pop qualification and next occupancy
  always_comb begin
    cap_s       = clk_0_h & ~clk_0_h_d_r & ~freeze_i;
    pop_s       = (level_r != {LW{1'b0}}) & vec_ready_i;
    full_s      = (level_r == LVL_FULL_C);
    push_s      = cap_s & (~full_s | pop_s);
    drop_s      = cap_s & ~push_s;
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE_C;
      2'b01:   level_nxt_s = level_r - LVL_ONE_C;
      default: level_nxt_s = level_r;
    endcase
  end

  // Control state: pointers, occupancy, sequence and overflow counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      seq_cnt_r   <= 8'd0;
      ovf_r       <= 1'b0;
      ovf_cnt_r   <= 8'd0;
      clk_0_h_d_r <= 1'b1;
    end else begin
      clk_0_h_d_r <= clk_0_h;
      if (flush_i) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        level_r  <= {LW{1'b0}};
      end else begin
        level_r <= level_nxt_s;
        if (push_s) begin
          wr_ptr_r  <= wr_ptr_r + PTR_ONE_C;
          seq_cnt_r <= seq_cnt_r + 8'd1;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
        end
        if (drop_s) begin
          ovf_r <= 1'b1;
          if (ovf_cnt_r != 8'hFF) begin
            ovf_cnt_r <= ovf_cnt_r + 8'd1;
          end
        end
      end
    end
  end

  // Storage is not reset; only entries below level_r are ever exposed
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_s) begin
      mem_r[wr_ptr_r] <= {sut_valid_i, sut_data_i, seq_cnt_r};
    end
  end

  // Head presentation, masked to zero while empty
  always_comb begin
    head_s      = mem_r[rd_ptr_r];
    vec_valid_o = (level_r != {LW{1'b0}});
    if (vec_valid_o) begin
      vec_data_o = head_s[16:8];
      vec_seq_o  = head_s[7:0];
    end else begin
      vec_data_o = 9'd0;
      vec_seq_o  = 8'd0;
    end
  end

  assign level_o      = level_r;
  assign freeze_req_o = (32'(level_r) >= FREEZE_TH_C);
  assign ovf_o        = ovf_r;
  assign ovf_cnt_o    = ovf_cnt_r;

endmodule

// File: tb/tb_part_2_trgt_upld_buf.sv
// Directed table-driven bench for part_2_trgt_upld_buf (DEPTH=4, FREEZE_TH=3).
module tb_part_2_trgt_upld_buf;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clk_0_h;
  logic       freeze_i;
  logic       flush_i;
  logic       sut_valid_i;
  logic [7:0] sut_data_i;
  logic       vec_valid_o;
  logic [8:0] vec_data_o;
  logic [7:0] vec_seq_o;
  logic       vec_ready_i;
  logic [2:0] level_o;
  logic       freeze_req_o;
  logic       ovf_o;
  logic [7:0] ovf_cnt_o;

  int checks = 0;
  int errors = 0;

  part_2_trgt_upld_buf #(.DEPTH(4), .FREEZE_TH(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_0_h(clk_0_h), .freeze_i(freeze_i),
    .flush_i(flush_i), .sut_valid_i(sut_valid_i), .sut_data_i(sut_data_i),
    .vec_valid_o(vec_valid_o), .vec_data_o(vec_data_o), .vec_seq_o(vec_seq_o),
    .vec_ready_i(vec_ready_i), .level_o(level_o), .freeze_req_o(freeze_req_o),
    .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       c, fz, fl, sv;
    logic [7:0] sd;
    logic       rdy;
    logic       ev;
    logic [8:0] ed;
    logic [7:0] es;
    logic [2:0] el;
    logic       efr, eo;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, fz, fl, sv, input logic [7:0] sd, input logic rdy,
                     input logic ev, input logic [8:0] ed, input logic [7:0] es,
                     input logic [2:0] el, input logic efr, eo, input logic [7:0] ec);
    vec_t v;
    v.c = c; v.fz = fz; v.fl = fl; v.sv = sv; v.sd = sd; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.es = es; v.el = el; v.efr = efr; v.eo = eo; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic c, fz, fl, sv, input logic [7:0] sd, input logic rdy);
    clk_0_h = c; freeze_i = fz; flush_i = fl; sut_valid_i = sv; sut_data_i = sd;
    vec_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(input string p, input logic ev, input logic [8:0] ed,
                         input logic [7:0] es, input logic [2:0] el, input logic efr,
                         input logic eo, input logic [7:0] ec);
    chk({p, "_valid"}, 32'(vec_valid_o), 32'(ev));
    chk({p, "_data"}, 32'(vec_data_o), 32'(ed));
    chk({p, "_seq"}, 32'(vec_seq_o), 32'(es));
    chk({p, "_level"}, 32'(level_o), 32'(el));
    chk({p, "_freeze_req"}, 32'(freeze_req_o), 32'(efr));
    chk({p, "_ovf"}, 32'(ovf_o), 32'(eo));
    chk({p, "_ovf_cnt"}, 32'(ovf_cnt_o), 32'(ec));
  endtask

  initial begin
    //   c  fz fl sv sd     rdy  ev ed      es     el   fr  o   cnt
    add(1, 0, 0, 0, 8'h00, 0,   0, 9'h000, 8'h00, 3'd0, 0, 0, 8'd0); // high at release: no capture
    add(0, 0, 0, 0, 8'h00, 0,   0, 9'h000, 8'h00, 3'd0, 0, 0, 8'd0);
    add(1, 0, 0, 1, 8'hA5, 0,   1, 9'h1A5, 8'h00, 3'd1, 0, 0, 8'd0); // single capture
    add(0, 0, 0, 0, 8'h3C, 0,   1, 9'h1A5, 8'h00, 3'd1, 0, 0, 8'd0);
    add(1, 0, 0, 0, 8'h3C, 0,   1, 9'h1A5, 8'h00, 3'd2, 0, 0, 8'd0);
    add(0, 0, 0, 0, 8'h3C, 0,   1, 9'h1A5, 8'h00, 3'd2, 0, 0, 8'd0);
    add(1, 0, 0, 1, 8'h11, 0,   1, 9'h1A5, 8'h00, 3'd3, 1, 0, 8'd0);
    add(0, 0, 0, 1, 8'h11, 0,   1, 9'h1A5, 8'h00, 3'd3, 1, 0, 8'd0);
    add(1, 0, 0, 1, 8'h22, 0,   1, 9'h1A5, 8'h00, 3'd4, 1, 0, 8'd0);
    add(0, 0, 0, 1, 8'h22, 0,   1, 9'h1A5, 8'h00, 3'd4, 1, 0, 8'd0);
    add(1, 0, 0, 1, 8'h33, 0,   1, 9'h1A5, 8'h00, 3'd4, 1, 1, 8'd1); // full: drop
    add(0, 0, 0, 1, 8'h33, 0,   1, 9'h1A5, 8'h00, 3'd4, 1, 1, 8'd1);
    add(1, 0, 0, 1, 8'h33, 0,   1, 9'h1A5, 8'h00, 3'd4, 1, 1, 8'd2);
    add(0, 0, 0, 0, 8'h00, 1,   1, 9'h03C, 8'h01, 3'd3, 1, 1, 8'd2);
    add(1, 0, 0, 1, 8'h44, 0,   1, 9'h03C, 8'h01, 3'd4, 1, 1, 8'd2);
    add(0, 0, 0, 0, 8'h00, 0,   1, 9'h03C, 8'h01, 3'd4, 1, 1, 8'd2);
    add(1, 0, 0, 1, 8'h55, 1,   1, 9'h111, 8'h02, 3'd4, 1, 1, 8'd2); // full + pop: accepted
    add(0, 0, 0, 0, 8'h00, 1,   1, 9'h122, 8'h03, 3'd3, 1, 1, 8'd2);
    add(0, 0, 0, 0, 8'h00, 1,   1, 9'h144, 8'h04, 3'd2, 0, 1, 8'd2);
    add(0, 0, 0, 0, 8'h00, 1,   1, 9'h155, 8'h05, 3'd1, 0, 1, 8'd2);
    add(0, 0, 0, 0, 8'h00, 1,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2);
    add(0, 0, 0, 0, 8'h00, 1,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2); // ready on empty
    add(1, 1, 0, 1, 8'h66, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2); // frozen edges
    add(0, 1, 0, 1, 8'h66, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2);
    add(1, 1, 0, 1, 8'h66, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2);
    add(0, 1, 0, 1, 8'h66, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2);
    add(1, 1, 0, 1, 8'h66, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2);
    add(0, 0, 0, 1, 8'h66, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd2);
    add(1, 0, 0, 1, 8'h66, 0,   1, 9'h166, 8'h06, 3'd1, 0, 1, 8'd2); // first edge after unfreeze
    add(0, 0, 0, 0, 8'h77, 0,   1, 9'h166, 8'h06, 3'd1, 0, 1, 8'd2);
    add(1, 0, 0, 0, 8'h77, 0,   1, 9'h166, 8'h06, 3'd2, 0, 1, 8'd2);
    add(0, 0, 0, 1, 8'h88, 0,   1, 9'h166, 8'h06, 3'd2, 0, 1, 8'd2);
    add(1, 0, 0, 1, 8'h88, 0,   1, 9'h166, 8'h06, 3'd3, 1, 1, 8'd2);
    add(0, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd3, 1, 1, 8'd2);
    add(1, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd2);
    add(0, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd2);
    add(1, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd3);
    add(0, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd3);
    add(1, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd4);
    add(0, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd4);
    add(1, 0, 0, 1, 8'h99, 0,   1, 9'h166, 8'h06, 3'd4, 1, 1, 8'd5);
    add(0, 0, 0, 0, 8'h00, 1,   1, 9'h077, 8'h07, 3'd3, 1, 1, 8'd5);
    add(1, 0, 1, 1, 8'hAA, 1,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd5); // flush beats push+pop
    add(0, 0, 0, 1, 8'hBB, 0,   0, 9'h000, 8'h00, 3'd0, 0, 1, 8'd5);
    add(1, 0, 0, 1, 8'hBB, 0,   1, 9'h1BB, 8'h0A, 3'd1, 0, 1, 8'd5); // seq kept across flush

    rst_i = 1'b1;
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk_all("reset", 0, 9'h000, 8'h00, 3'd0, 0, 0, 8'd0);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].fz, tbl[i].fl, tbl[i].sv, tbl[i].sd, tbl[i].rdy);
      chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].el,
              tbl[i].efr, tbl[i].eo, tbl[i].ec);
    end

    // Reset mid-operation with clk_0_h held high; also overrides flush/pop/capture
    rst_i = 1'b1;
    step(1, 0, 1, 1, 8'hCC, 1);
    step(1, 0, 1, 1, 8'hCC, 1);
    chk_all("rst_mid", 0, 9'h000, 8'h00, 3'd0, 0, 0, 8'd0);
    rst_i = 1'b0;
    step(1, 0, 0, 1, 8'hCC, 0);
    chk_all("rst_release", 0, 9'h000, 8'h00, 3'd0, 0, 0, 8'd0);

    // 257 captures drained immediately: sequence wraps 255 -> 0 with no overflow
    for (int i = 0; i < 257; i++) begin
      logic [7:0] d;
      d = 8'(i);
      step(0, 0, 0, 1, d, 1);
      step(1, 0, 0, 1, d, 1);
      chk($sformatf("wrap%0d_valid", i), 32'(vec_valid_o), 32'd1);
      chk($sformatf("wrap%0d_seq", i), 32'(vec_seq_o), 32'(d));
      chk($sformatf("wrap%0d_data", i), 32'(vec_data_o), 32'({1'b1, d}));
    end
    step(0, 0, 0, 0, 8'h00, 1);
    chk_all("wrap_end", 0, 9'h000, 8'h00, 3'd0, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
